mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 17 +
 rtl/mul_div_unit_div_step.sv | 20 ++
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared ISA function codes and datapath widths for the HI/LO multiply-divide unit.
package mul_div_unit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

    localparam logic [5:0] FUN_MFHI  = 6'b010000;
    localparam logic [5:0] FUN_MTHI  = 6'b010001;
    localparam logic [5:0] FUN_MFLO  = 6'b010010;
    localparam logic [5:0] FUN_MTLO  = 6'b010011;
    localparam logic [5:0] FUN_MULT  = 6'b011000;
    localparam logic [5:0] FUN_MULTU = 6'b011001;
    localparam logic [5:0] FUN_DIV   = 6'b011010;
    localparam logic [5:0] FUN_DIVU  = 6'b011011;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-divide iteration; the trial subtraction itself is done by the
// adder shared with the multiplier, which returns the difference and no-borrow flag.
module div_step
    import mul_div_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] diff_i,
    input  logic              no_borrow_i,
    output logic [DATA_W:0]   trial_o,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    assign trial_o = {rem_i, quo_i[DATA_W-1]};
    // Remainder stays below the divisor, so a successful subtraction fits in DATA_W bits.
    assign rem_o   = no_borrow_i ? diff_i : trial_o[DATA_W-1:0];
    assign quo_o   = {quo_i[DATA_W-2:0], no_borrow_i};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32 radix-2 steps on operand magnitudes,
// then one FIX cycle that applies sign correction and writes HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        aluFunct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] work_hi_q, work_hi_d, work_lo_q, work_lo_d;
    logic [DATA_W-1:0] op_b_q, op_b_d, a_raw_q, a_raw_d;
    logic is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic div0_q, div0_d, done_q, done_d;

    logic              is_mul_op, is_div_op, is_signed_op;
    logic [DATA_W:0]   add_a, add_b, mul_s, trial;
    logic              add_cin;
    logic [DATA_W+1:0] add_sum;
    logic [DATA_W-1:0] div_rem, div_quo;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_if_wide(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v, input logic sgn);
        return neg_if(v, sgn && (v < 0));
    endfunction

    assign is_mul_op    = (aluFunct == FUN_MULT) || (aluFunct == FUN_MULTU);
    assign is_div_op    = (aluFunct == FUN_DIV)  || (aluFunct == FUN_DIVU);
    assign is_signed_op = (aluFunct == FUN_MULT) || (aluFunct == FUN_DIV);

    // One 33-bit adder: multiplicand accumulate in MUL, trial subtract in DIV.
    always_comb begin
        add_a   = {1'b0, work_hi_q};
        add_b   = {1'b0, op_b_q};
        add_cin = 1'b0;
        if (state_q == ST_DIV) begin
            add_a   = trial;
            add_b   = ~{1'b0, op_b_q};
            add_cin = 1'b1;
        end
    end

    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(DATA_W+1){1'b0}}, add_cin};
    assign mul_s   = work_lo_q[0] ? add_sum[DATA_W:0] : {1'b0, work_hi_q};

    div_step u_div_step (
        .rem_i       (work_hi_q),
        .quo_i       (work_lo_q),
        .diff_i      (add_sum[DATA_W-1:0]),
        .no_borrow_i (add_sum[DATA_W+1]),
        .trial_o     (trial),
        .rem_o       (div_rem),
        .quo_o       (div_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && is_mul_op)      state_d = ST_MUL;
                         else if (start && is_div_op) state_d = ST_DIV;
                ST_MUL, ST_DIV: if (cnt_q == ITER_LAST) state_d = ST_FIX;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        hi_d = hi_q;           lo_d = lo_q;
        work_hi_d = work_hi_q; work_lo_d = work_lo_q;
        op_b_d = op_b_q;       a_raw_d = a_raw_q;
        is_div_d = is_div_q;   neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q; div0_d = div0_q;
        cnt_d = cnt_q;         done_d = 1'b0;
        case (state_q)
            ST_IDLE: if (start && !flush) begin
                if (is_mul_op || is_div_op) begin
                    work_hi_d = '0;
                    work_lo_d = magnitude(a, is_signed_op);
                    op_b_d    = magnitude(b, is_signed_op);
                    a_raw_d   = a;
                    is_div_d  = is_div_op;
                    neg_res_d = is_signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
                    neg_rem_d = is_signed_op && a[DATA_W-1];
                    div0_d    = (b == '0);
                    cnt_d     = '0;
                end
                if (aluFunct == FUN_MTHI) hi_d = a;
                if (aluFunct == FUN_MTLO) lo_d = a;
            end
            ST_MUL: begin
                {work_hi_d, work_lo_d} = {mul_s, work_lo_q[DATA_W-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_DIV: begin
                work_hi_d = div_rem;
                work_lo_d = div_quo;
                cnt_d     = cnt_q + CNT_W'(1);
            end
            default: if (!flush) begin
                done_d = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_if_wide({work_hi_q, work_lo_q}, neg_res_q);
                end else if (div0_q) begin
                    lo_d = '1;
                    hi_d = a_raw_q;
                end else begin
                    lo_d = neg_if(work_lo_q, neg_res_q);
                    hi_d = neg_if(work_hi_q, neg_rem_q);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;     hi_q <= '0;      lo_q <= '0;
            work_hi_q <= '0; work_lo_q <= '0; op_b_q <= '0; a_raw_q <= '0;
            is_div_q <= 1'b0; neg_res_q <= 1'b0; neg_rem_q <= 1'b0;
            div0_q <= 1'b0;  done_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;         hi_q <= hi_d;           lo_q <= lo_d;
            work_hi_q <= work_hi_d; work_lo_q <= work_lo_d; op_b_q <= op_b_d; a_raw_q <= a_raw_d;
            is_div_q <= is_div_d;   neg_res_q <= neg_res_d; neg_rem_q <= neg_rem_d;
            div0_q <= div0_d;       done_q <= done_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (aluFunct == FUN_MFHI)      rdata = hi_q;
        else if (aluFunct == FUN_MFLO) rdata = lo_q;
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results.
module tb_mul_div_unit;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
    logic [5:0]  aluFunct = 6'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] hi, lo, rdata;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluFunct(aluFunct),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results straight from integer arithmetic: returns {hi, lo}.
    function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = $signed(x);
        sy = $signed(y);
        res = '0;
        case (f)
            F_MULT:  begin q = sx * sy; res = q; end
            F_MULTU: res = {32'd0, x} * {32'd0, y};
            F_DIV:   if (y == 0) res = {x, 32'hFFFFFFFF};
                     else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
            F_DIVU:  if (y == 0) res = {x, 32'hFFFFFFFF};
                     else res = {x % y, x / y};
            default: res = '0;
        endcase
        return res;
    endfunction

    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_rem = 0;
    logic        m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_rem <= 0;
            end else if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                case (aluFunct)
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        m_res <= model_result(aluFunct, a, b);
                        m_rem <= 33;
                    end
                    F_MTHI:  m_hi <= a;
                    F_MTLO:  m_lo <= a;
                    default: ;
                endcase
            end
        end
    end

    logic cmp_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
            check("cyc_busy", busy, m_rem > 0);
            check("cyc_done", done, m_done);
            check("cyc_rdata", rdata, (aluFunct == F_MFHI) ? m_hi : (aluFunct == F_MFLO) ? m_lo : 32'd0);
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; aluFunct = f; a = x; b = y;
        @(negedge clk);
        start = 1'b0; aluFunct = 6'd0;
    endtask

    task automatic wait_done(output int cyc);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            seen = done;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL wait_done: done not seen within %0d cycles", n);
        end
        cyc = n;
    endtask

    task automatic count_done(input int ncyc, output int cnt);
        cnt = 0;
        repeat (ncyc) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        issue(f, x, y);
        wait_done(cyc);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        check({name, "_model"}, {m_hi, m_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        int cyc, dcnt;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        issue(F_MULT, 32'hFFFFFFFF, 32'h00000002);
        wait_done(cyc);
        check("mult_latency", cyc + 1, 34);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);

        run_op("multu",     F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult_min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negb",  F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_zero", F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
        run_op("div_zero",  F_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_big",  F_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999);

        issue(F_MTHI, 32'h12345678, 32'h0);
        aluFunct = F_MFHI;
        #1;
        check("mfhi_rdata", rdata, 32'h12345678);
        check("mthi_busy", busy, 1'b0);
        check("mthi_done", done, 1'b0);
        issue(F_MTLO, 32'hCAFEF00D, 32'h0);
        aluFunct = F_MFLO;
        #1;
        check("mflo_rdata", rdata, 32'hCAFEF00D);
        aluFunct = F_ADD;
        #1;
        check("other_rdata", rdata, 32'd0);
        aluFunct = 6'd0;

        issue(F_DIV, 32'd64, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_hi", hi, 32'h12345678);
        check("flush_lo", lo, 32'hCAFEF00D);
        count_done(40, dcnt);
        check("flush_no_done", dcnt, 0);
        run_op("mult_after_flush", F_MULT, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFF1);

        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc);
        check("multu_max_hi", hi, 32'hFFFFFFFE);
        check("multu_max_lo", lo, 32'h00000001);
        run_op("divu_b2b", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        issue(F_MULT, 32'h00001234, 32'h00005678);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, dcnt);
        check("midrst_no_done", dcnt, 0);
        run_op("mult_after_rst", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
